tank_motion_ctrl: RTL
=====================

# tank_motion_ctrl

Parametrised per-player tank motion controller, one instance per player, clocked once per video frame. It converts a keycode into facing and position updates, clamping at the play-field edges and honouring barrier-collision flags. It adds a hit, death and respawn state machine with an invulnerability window, and an optional turn-before-move mode. Outputs feed the sprite renderer, the barrier-collision checker and the projectile spawner.

## Interface
Parameters:
- POS_W, 10, position/size width
- X_CENTER, 480, respawn/reset X
- Y_CENTER, 240, respawn/reset Y
- X_MIN / X_MAX, 1 / 639, horizontal field bounds
- Y_MIN / Y_MAX, 1 / 479, vertical field bounds
- SIZE, 8, tank half-extent (BallS)
- STEP_SLOW / STEP_FAST, 1 / 3, pixels per frame without / with speed_upgrade
- KEY_LEFT / KEY_RIGHT / KEY_DOWN / KEY_UP, 80 / 79 / 81 / 82, keycodes
- DIR_INIT, 2'b00, facing at reset/respawn
- RESPAWN_FRAMES, 120, dead duration (≥1)
- INVULN_FRAMES, 180, post-respawn invulnerability (≥1)
- TURN_FIRST, 1, 1 = a direction change consumes one frame without moving; 0 = turn and move in the same frame

Ports:
- frame_clk  in  1  frame clock, one rising edge per frame
- Reset_n  in  1  asynchronous, active-low reset
- keycode  in  8  current key
- speed_upgrade  in  1  selects STEP_FAST
- barrier_collision  in  4  [0] blocks right, [1] left, [2] down, [3] up
- hit  in  1  projectile hit this frame
- BallX, BallY  out  POS_W  tank centre
- BallS  out  POS_W  constant SIZE
- direction  out  2  00 left, 01 right, 10 down, 11 up
- alive  out  1  0 while DEAD
- invulnerable  out  1  1 while SPAWN
- moving  out  1  position changed on the last edge

## Operation
- Legal centre range: LO_X = X_MIN+SIZE, HI_X = X_MAX−SIZE. Y uses the same rule. Position never leaves [LO, HI].
- Step arithmetic runs at POS_W+2 bits signed.
  - Left: X' = max(X−step, LO_X).
  - Right: X' = min(X+step, HI_X).
  - Y moves the same way.
  - step is STEP_FAST if speed_upgrade, else STEP_SLOW.
- Movement is suppressed when the barrier bit for the key's direction is set. Facing still updates.
- TURN_FIRST=1: if the key direction ≠ direction, update direction only. moving=0.
- Any other keycode: hold position and direction, moving=0.
- States:
  - ACTIVE
    - Movement enabled.
    - On hit, go to DEAD and load cnt=RESPAWN_FRAMES−1.
    - Hit takes priority over a key in the same frame: no movement that frame.
  - DEAD
    - alive=0, keys ignored, position held, hit ignored.
    - cnt decrements each frame.
    - At cnt==0: go to SPAWN, set X/Y to the centre, direction=DIR_INIT, cnt=INVULN_FRAMES−1.
  - SPAWN
    - Movement enabled, invulnerable=1, hit ignored.
    - At cnt==0: go to ACTIVE.
- Reset in any state returns to ACTIVE at the centre, cnt=0.

## Timing
- All outputs are registered and update on the rising edge of frame_clk. A key sampled at edge N is reflected on the outputs after edge N.
- Reset values:
  - BallX=X_CENTER, BallY=Y_CENTER, direction=DIR_INIT
  - alive=1, invulnerable=0, moving=0
  - state=ACTIVE
- DEAD lasts exactly RESPAWN_FRAMES edges. SPAWN lasts exactly INVULN_FRAMES edges.
- The centre load and alive=1 occur on the same edge as DEAD→SPAWN.
- BallS is combinational constant SIZE.

## Structure
- tank_pkg holds:
  - dir_t enum (DIR_LEFT, DIR_RIGHT, DIR_DOWN, DIR_UP)
  - state_t enum (ST_ACTIVE, ST_DEAD, ST_SPAWN)
  - default keycode constants
- Sub-module tank_axis_step, instantiated for X and for Y: combinational clamped add/subtract (pos, step, dir_neg, lo, hi → next).
- Counter width: $clog2(max(RESPAWN_FRAMES, INVULN_FRAMES)).

## Test plan
- Reset, then KEY_RIGHT with direction=00, TURN_FIRST=1 → edge 1: direction=01, BallX=480. Edge 2: BallX=481, moving=1.
- X=630, KEY_RIGHT, speed_upgrade=1 → BallX=631 (clamped), then holds at 631, moving=0.
- KEY_UP with barrier_collision[3]=1 → direction=11, BallY unchanged for 10 frames.
- hit together with KEY_LEFT in ACTIVE → BallX unchanged, alive=0. After 120 edges: alive=1, invulnerable=1, X/Y=480/240. A hit during the following 180 edges is ignored. Then invulnerable=0.
- Reset_n low at DEAD frame 50 → immediately alive=1, state ACTIVE, position at centre.
- TURN_FIRST=0, keycode=KEY_DOWN from facing left → direction=10 and BallY=241 on the same edge.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types and default keycodes for the per-player tank motion controller.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DEAD   = 2'd1,
    ST_SPAWN  = 2'd2
  } state_t;

  localparam logic [7:0] KEY_LEFT_DEF  = 8'd80;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'd79;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'd81;
  localparam logic [7:0] KEY_UP_DEF    = 8'd82;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tank_motion_ctrl_if.sv
// Bundles the per-frame player inputs and the tank state outputs of one player.
interface tank_motion_ctrl_if #(
  parameter int POS_W = 10
);
  // No handshake: inputs are level signals sampled on every frame_clk rising
  // edge, outputs are registered and hold their value for the whole frame.
  logic [7:0]       keycode;
  logic             speed_upgrade;
  logic [3:0]       barrier_collision;
  logic             hit;
  logic [POS_W-1:0] BallX;
  logic [POS_W-1:0] BallY;
  logic [POS_W-1:0] BallS;
  logic [1:0]       direction;
  logic             alive;
  logic             invulnerable;
  logic             moving;

  modport master (
    output keycode, speed_upgrade, barrier_collision, hit,
    input  BallX, BallY, BallS, direction, alive, invulnerable, moving
  );

  modport slave (
    input  keycode, speed_upgrade, barrier_collision, hit,
    output BallX, BallY, BallS, direction, alive, invulnerable, moving
  );
endinterface

// File: rtl/tank_axis_step.sv
// One-axis clamped step: moves pos by step toward lo (dir_neg) or hi, saturating at the bound.
module tank_axis_step #(
  parameter int POS_W = 10
) (
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W-1:0] step,
  input  logic             dir_neg,
  input  logic [POS_W-1:0] lo,
  input  logic [POS_W-1:0] hi,
  output logic [POS_W-1:0] next
);

  // Two extra bits so a step past zero or past the top of the range stays visible.
  logic signed [POS_W+1:0] sum;

  always_comb begin
    if (dir_neg) begin
      sum = $signed({2'b00, pos}) - $signed({2'b00, step});
    end else begin
      sum = $signed({2'b00, pos}) + $signed({2'b00, step});
    end
    next = sum[POS_W-1:0];
    if (dir_neg && (sum < $signed({2'b00, lo}))) begin
      next = lo;
    end
    if (!dir_neg && (sum > $signed({2'b00, hi}))) begin
      next = hi;
    end
  end

endmodule

// File: rtl/tank_motion_ctrl.sv
// Per-player tank motion: key-driven clamped movement plus hit/dead/respawn FSM
// with a post-respawn invulnerability window.
module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter int         POS_W          = 10,
  parameter int         X_CENTER       = 480,
  parameter int         Y_CENTER       = 240,
  parameter int         X_MIN          = 1,
  parameter int         X_MAX          = 639,
  parameter int         Y_MIN          = 1,
  parameter int         Y_MAX          = 479,
  parameter int         SIZE           = 8,
  parameter int         STEP_SLOW      = 1,
  parameter int         STEP_FAST      = 3,
  parameter logic [7:0] KEY_LEFT       = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT      = KEY_RIGHT_DEF,
  parameter logic [7:0] KEY_DOWN       = KEY_DOWN_DEF,
  parameter logic [7:0] KEY_UP         = KEY_UP_DEF,
  parameter logic [1:0] DIR_INIT       = 2'b00,
  parameter int         RESPAWN_FRAMES = 120,
  parameter int         INVULN_FRAMES  = 180,
  parameter bit         TURN_FIRST     = 1'b1
) (
  input  logic             frame_clk,
  input  logic             Reset_n,
  input  logic [7:0]       keycode,
  input  logic             speed_upgrade,
  input  logic [3:0]       barrier_collision,
  input  logic             hit,
  output logic [POS_W-1:0] BallX,
  output logic [POS_W-1:0] BallY,
  output logic [POS_W-1:0] BallS,
  output logic [1:0]       direction,
  output logic             alive,
  output logic             invulnerable,
  output logic             moving,
  output state_t           dbg_state
);

  localparam int CNT_MAX = max2(RESPAWN_FRAMES, INVULN_FRAMES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] INV_LOAD  = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [POS_W-1:0] LO_X = POS_W'(X_MIN + SIZE);
  localparam logic [POS_W-1:0] HI_X = POS_W'(X_MAX - SIZE);
  localparam logic [POS_W-1:0] LO_Y = POS_W'(Y_MIN + SIZE);
  localparam logic [POS_W-1:0] HI_Y = POS_W'(Y_MAX - SIZE);
  localparam logic [POS_W-1:0] X_C  = POS_W'(X_CENTER);
  localparam logic [POS_W-1:0] Y_C  = POS_W'(Y_CENTER);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  dir_t             dir_q, dir_d;
  logic             moving_q, moving_d;

  logic             key_valid;
  dir_t             key_dir;
  logic             blocked;
  logic             move_ok;
  logic [POS_W-1:0] step;
  logic [POS_W-1:0] x_step, y_step;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_LEFT;
    blocked   = 1'b0;
    if (keycode == KEY_LEFT) begin
      key_dir = DIR_LEFT;
      blocked = barrier_collision[1];
    end else if (keycode == KEY_RIGHT) begin
      key_dir = DIR_RIGHT;
      blocked = barrier_collision[0];
    end else if (keycode == KEY_DOWN) begin
      key_dir = DIR_DOWN;
      blocked = barrier_collision[2];
    end else if (keycode == KEY_UP) begin
      key_dir = DIR_UP;
      blocked = barrier_collision[3];
    end else begin
      key_valid = 1'b0;
    end
  end

  assign step = speed_upgrade ? POS_W'(STEP_FAST) : POS_W'(STEP_SLOW);

  tank_axis_step #(.POS_W(POS_W)) u_step_x (
    .pos(x_q), .step(step), .dir_neg(key_dir == DIR_LEFT),
    .lo(LO_X), .hi(HI_X), .next(x_step)
  );

  tank_axis_step #(.POS_W(POS_W)) u_step_y (
    .pos(y_q), .step(step), .dir_neg(key_dir == DIR_UP),
    .lo(LO_Y), .hi(HI_Y), .next(y_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    moving_d = 1'b0;
    move_ok  = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        // A hit wins over any key in the same frame.
        if (hit) begin
          state_d = ST_DEAD;
          cnt_d   = RESP_LOAD;
        end else begin
          move_ok = 1'b1;
        end
      end
      ST_DEAD: begin
        if (cnt_q == '0) begin
          state_d = ST_SPAWN;
          cnt_d   = INV_LOAD;
          x_d     = X_C;
          y_d     = Y_C;
          dir_d   = dir_t'(DIR_INIT);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SPAWN: begin
        move_ok = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase

    if (move_ok && key_valid) begin
      dir_d = key_dir;
      if (!(TURN_FIRST && (key_dir != dir_q)) && !blocked) begin
        if ((key_dir == DIR_LEFT) || (key_dir == DIR_RIGHT)) begin
          x_d      = x_step;
          moving_d = (x_step != x_q);
        end else begin
          y_d      = y_step;
          moving_d = (y_step != y_q);
        end
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_ACTIVE;
      cnt_q    <= '0;
      x_q      <= X_C;
      y_q      <= Y_C;
      dir_q    <= dir_t'(DIR_INIT);
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
    end
  end

  assign BallX        = x_q;
  assign BallY        = y_q;
  assign BallS        = POS_W'(SIZE);
  assign direction    = dir_q;
  assign alive        = (state_q != ST_DEAD);
  assign invulnerable = (state_q == ST_SPAWN);
  assign moving       = moving_q;
  assign dbg_state    = state_q;

endmodule
